// File: rtl/ula_sequencial.sv
`default_nettype none
// ============================================================================
//  Module   : ula_sequencial
//  Purpose  : LARGURA-bit ALU with registered outputs. Seven single-cycle
//             operations (AND, OR, XOR, NOR, ADD, SUB, SLT) plus a
//             multi-cycle shift-add multiplier behind a start/busy/valid
//             handshake.
//  Ports    : clock      - rising-edge clock
//             reset_n    - synchronous active-low reset
//             inicio     - start request, sampled on rising edge
//             operacao   - operation select, sampled with inicio
//             entrada1   - operand A, sampled with inicio
//             entrada2   - operand B, sampled with inicio
//             resultado  - registered result, held until next completion
//             zero       - registered, 1 when resultado == 0
//             valido     - one-cycle pulse when a new resultado appears
//             ocupado    - high while a multiplication is in progress
//  Revision : 1.0 - initial release
// ============================================================================
module ula_sequencial #(
    parameter int LARGURA = 32
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               inicio,
    input  logic [2:0]         operacao,
    input  logic [LARGURA-1:0] entrada1,
    input  logic [LARGURA-1:0] entrada2,
    output logic [LARGURA-1:0] resultado,
    output logic               zero,
    output logic               valido,
    output logic               ocupado
);

    localparam logic [0:0] OCIOSO = 1'b0;
    localparam logic [0:0] MULT   = 1'b1;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOR = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    // Counter only needs to reach LARGURA-1.
    localparam int                CW     = (LARGURA > 2) ? $clog2(LARGURA) : 1;
    localparam logic [CW-1:0]     ULTIMO = CW'(LARGURA - 1);

    logic [0:0]         estado;
    logic [LARGURA-1:0] multiplicando;
    logic [LARGURA-1:0] multiplicador;
    logic [LARGURA-1:0] acumulador;
    logic [CW-1:0]      contador;

    logic [LARGURA-1:0] alu;
    logic [LARGURA-1:0] acumulador_prox;
    logic               menor;

    assign menor = $signed(entrada1) < $signed(entrada2);

    always_comb begin
        alu = '0;
        case (operacao)
            OP_AND:  alu = entrada1 & entrada2;
            OP_OR:   alu = entrada1 | entrada2;
            OP_XOR:  alu = entrada1 ^ entrada2;
            OP_NOR:  alu = ~(entrada1 | entrada2);
            OP_ADD:  alu = entrada1 + entrada2;
            OP_SUB:  alu = entrada1 - entrada2;
            OP_SLT:  alu = {{(LARGURA-1){1'b0}}, menor};
            default: alu = '0;  // MUL goes through the sequential path
        endcase
    end

    // One shift-add step; the carry out of the top bit is discarded, which
    // keeps only the low LARGURA bits of the product.
    assign acumulador_prox = multiplicador[0] ? (acumulador + multiplicando)
                                              : acumulador;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            estado        <= OCIOSO;
            resultado     <= '0;
            zero          <= 1'b1;
            valido        <= 1'b0;
            ocupado       <= 1'b0;
            multiplicando <= '0;
            multiplicador <= '0;
            acumulador    <= '0;
            contador      <= '0;
        end else begin
            valido <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (inicio) begin
                        if (operacao == OP_MUL) begin
                            multiplicando <= entrada1;
                            multiplicador <= entrada2;
                            acumulador    <= '0;
                            contador      <= '0;
                            estado        <= MULT;
                        end else begin
                            resultado <= alu;
                            zero      <= (alu == '0);
                            valido    <= 1'b1;
                        end
                    end
                end
                MULT: begin
                    acumulador    <= acumulador_prox;
                    multiplicando <= multiplicando << 1;
                    multiplicador <= multiplicador >> 1;
                    contador      <= contador + CW'(1);
                    // Busy rises after the first iteration and drops with the
                    // result, so it is high for LARGURA-1 cycles and never
                    // overlaps valido.
                    ocupado       <= (contador != ULTIMO);
                    if (contador == ULTIMO) begin
                        resultado <= acumulador_prox;
                        zero      <= (acumulador_prox == '0);
                        valido    <= 1'b1;
                        contador  <= '0;
                        estado    <= OCIOSO;
                    end
                end
                default: estado <= OCIOSO;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ula_sequencial.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ula_sequencial
//  Purpose  : Self-checking bench for ula_sequencial (LARGURA=8 and 32).
//             Expected results are queued when an operation is issued and
//             popped when valido is observed.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ula_sequencial;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;

    logic       inicio = 1'b0;
    logic [2:0] operacao = 3'b000;
    logic [7:0] entrada1 = '0;
    logic [7:0] entrada2 = '0;
    logic [7:0] resultado;
    logic       zero, valido, ocupado;

    logic        inicio32 = 1'b0;
    logic [2:0]  operacao32 = 3'b000;
    logic [31:0] entrada1_32 = '0;
    logic [31:0] entrada2_32 = '0;
    logic [31:0] resultado32;
    logic        zero32, valido32, ocupado32;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] esperado_q[$];

    always #5 clock = ~clock;

    ula_sequencial #(.LARGURA(8)) dut8 (
        .clock(clock), .reset_n(reset_n), .inicio(inicio), .operacao(operacao),
        .entrada1(entrada1), .entrada2(entrada2), .resultado(resultado),
        .zero(zero), .valido(valido), .ocupado(ocupado)
    );

    ula_sequencial #(.LARGURA(32)) dut32 (
        .clock(clock), .reset_n(reset_n), .inicio(inicio32), .operacao(operacao32),
        .entrada1(entrada1_32), .entrada2(entrada2_32), .resultado(resultado32),
        .zero(zero32), .valido(valido32), .ocupado(ocupado32)
    );

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one request across a sampling edge; optionally queues its result.
    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp, input bit push);
        operacao = op;
        entrada1 = a;
        entrada2 = b;
        inicio   = 1'b1;
        if (push) esperado_q.push_back(exp);
        cycle();
        inicio   = 1'b0;
    endtask

    // Waits for valido (bounded), checks latency/busy cycles, pops and compares.
    task automatic wait_result(input int lat, input int busy_exp, input string tag);
        int n = 0;
        int busy = 0;
        int both = 0;
        logic [7:0] exp;
        while (!valido && n < 200) begin
            if (ocupado) busy++;
            cycle();
            n++;
            if (valido && ocupado) both++;
        end
        check({tag, "_lat"}, n, lat);
        check({tag, "_busy"}, busy, busy_exp);
        check({tag, "_overlap"}, both, 0);
        if (esperado_q.size() == 0) begin
            check({tag, "_queue"}, 1, 0);
        end else begin
            exp = esperado_q.pop_front();
            check({tag, "_res"}, resultado, exp);
            check({tag, "_zero"}, zero, (exp == 8'h00));
        end
    endtask

    initial begin
        int n;
        int vseen;

        // Reset
        reset_n = 1'b0;
        cycle();
        cycle();
        check("rst_res", resultado, 8'h00);
        check("rst_zero", zero, 1'b1);
        check("rst_valido", valido, 1'b0);
        check("rst_ocupado", ocupado, 1'b0);
        check("rst_res32", resultado32, 32'h0);
        reset_n = 1'b1;
        cycle();

        // Logic ops, issued back to back
        issue(3'b000, 8'h0C, 8'h0A, 8'h08, 1); wait_result(0, 0, "and");
        issue(3'b001, 8'h0C, 8'h0A, 8'h0E, 1); wait_result(0, 0, "or");
        issue(3'b010, 8'h0C, 8'h0A, 8'h06, 1); wait_result(0, 0, "xor");
        issue(3'b011, 8'h0C, 8'h0A, 8'hF1, 1); wait_result(0, 0, "nor");
        check("b2b_valido", valido, 1'b1);

        // AND truth table on bit 0
        issue(3'b000, 8'h00, 8'h00, 8'h00, 1); wait_result(0, 0, "tt00");
        issue(3'b000, 8'h00, 8'h01, 8'h00, 1); wait_result(0, 0, "tt01");
        issue(3'b000, 8'h01, 8'h00, 8'h00, 1); wait_result(0, 0, "tt10");
        issue(3'b000, 8'h01, 8'h01, 8'h01, 1); wait_result(0, 0, "tt11");
        cycle();
        check("idle_valido", valido, 1'b0);
        check("idle_hold", resultado, 8'h01);

        // Arithmetic wrap and signed compare
        issue(3'b100, 8'hFF, 8'h01, 8'h00, 1); wait_result(0, 0, "add_wrap");
        issue(3'b101, 8'h00, 8'h01, 8'hFF, 1); wait_result(0, 0, "sub_wrap");
        issue(3'b110, 8'h80, 8'h01, 8'h01, 1); wait_result(0, 0, "slt_neg");
        issue(3'b110, 8'h01, 8'h80, 8'h00, 1); wait_result(0, 0, "slt_pos");
        cycle();

        // Multiply
        issue(3'b111, 8'h0D, 8'h0B, 8'h8F, 1); wait_result(8, 7, "mul_0d0b");
        cycle();
        issue(3'b111, 8'hFF, 8'hFF, 8'h01, 1); wait_result(8, 7, "mul_ffff");
        cycle();
        issue(3'b111, 8'h00, 8'h37, 8'h00, 1); wait_result(8, 7, "mul_0037");
        cycle();

        // ADD pulsed mid-multiply is ignored; operands changed too
        issue(3'b111, 8'h0D, 8'h0B, 8'h8F, 1);
        cycle();
        cycle();
        issue(3'b100, 8'h01, 8'h01, 8'h02, 0);
        entrada1 = 8'h55;
        entrada2 = 8'h77;
        wait_result(5, 5, "mul_ignore");
        cycle();
        check("ignore_no_extra", valido, 1'b0);
        check("ignore_hold", resultado, 8'h8F);

        // Request accepted in the cycle the MUL result is valid
        issue(3'b111, 8'h03, 8'h05, 8'h0F, 1); wait_result(8, 7, "mul_03x05");
        issue(3'b000, 8'h0F, 8'h3C, 8'h0C, 1); wait_result(0, 0, "and_after_mul");

        // Reset mid-multiply: no valido for the aborted operation
        issue(3'b111, 8'h0D, 8'h0B, 8'h8F, 0);
        cycle();
        cycle();
        cycle();
        reset_n = 1'b0;
        operacao = 3'b000;
        inicio = 1'b1;       // reset must win over a simultaneous start
        cycle();
        inicio = 1'b0;
        check("midrst_res", resultado, 8'h00);
        check("midrst_zero", zero, 1'b1);
        check("midrst_valido", valido, 1'b0);
        check("midrst_ocupado", ocupado, 1'b0);
        reset_n = 1'b1;
        vseen = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (valido || ocupado) vseen++;
        end
        check("midrst_silent", vseen, 0);
        check("midrst_hold", resultado, 8'h00);

        // Width scaling with LARGURA=32
        operacao32  = 3'b111;
        entrada1_32 = 32'h0001_0000;
        entrada2_32 = 32'h0001_0000;
        inicio32    = 1'b1;
        cycle();
        inicio32    = 1'b0;
        n = 0;
        while (!valido32 && n < 200) begin
            cycle();
            n++;
        end
        check("mul32_lat", n, 32);
        check("mul32_res", resultado32, 32'h0000_0000);
        check("mul32_zero", zero32, 1'b1);

        operacao32  = 3'b111;
        entrada1_32 = 32'h0001_2345;
        entrada2_32 = 32'h0000_0100;
        inicio32    = 1'b1;
        cycle();
        inicio32    = 1'b0;
        n = 0;
        while (!valido32 && n < 200) begin
            cycle();
            n++;
        end
        check("mul32b_lat", n, 32);
        check("mul32b_res", resultado32, 32'h0123_4500);
        check("mul32b_zero", zero32, 1'b0);

        check("queue_empty", esperado_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
